// File: rtl/match_reporter.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// match_reporter
//
// Sits downstream of the string/MD5 match stage. Each search result is turned
// into a fixed 5-byte response packet and fed, one byte at a time, into a UART
// transmitter through its start/busy handshake:
//
//   byte 0 : SYNC_BYTE
//   byte 1 : status (8'h01 match, 8'h00 no match)
//   byte 2 : byte_pos[15:8]   (8'h00 on no match)
//   byte 3 : byte_pos[7:0]    (8'h00 on no match)
//   byte 4 : match_char       (8'h00 on no match)
//
// A result that arrives while a packet is in flight waits in a one-deep
// pending slot. A result that arrives while that slot is full is dropped,
// and the sticky overrun flag is raised.
//
// Ports
//   clk             : single clock, all registers on its rising edge
//   reset           : asynchronous, active-high reset
//   proc_done       : one-cycle pulse, the proc_* result fields are valid
//   proc_match      : 1 = hash match found
//   proc_byte_pos   : byte position of the match
//   proc_match_char : character at the match
//   txd_busy        : UART busy; rises the cycle after an accepted start
//   txd_start       : one-cycle request to transmit txd_data
//   txd_data        : registered byte to transmit
//   rpt_busy        : high while a packet is in flight or a result is pending
//   rpt_overrun     : sticky, a result was dropped; cleared only by reset
// -----------------------------------------------------------------------------
module match_reporter #(
  parameter logic [7:0] SYNC_BYTE = 8'hA5,
  parameter int         NUM_BYTES = 5
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        proc_done,
  input  logic        proc_match,
  input  logic [15:0] proc_byte_pos,
  input  logic [7:0]  proc_match_char,
  input  logic        txd_busy,
  output logic        txd_start,
  output logic [7:0]  txd_data,
  output logic        rpt_busy,
  output logic        rpt_overrun
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_START = 2'd1;  // txd_start is issued from here
  localparam logic [1:0] ST_GUARD = 2'd2;  // txd_busy not yet valid, ignored
  localparam logic [1:0] ST_WAIT  = 2'd3;  // wait for the transmitter to go idle

  localparam logic [2:0] LAST_IDX = 3'(NUM_BYTES - 1);

  // Packet byte selection; payload bytes are forced to zero on no match.
  function automatic logic [7:0] byte_sel(input logic [2:0]  idx,
                                          input logic        m,
                                          input logic [15:0] pos,
                                          input logic [7:0]  ch);
    logic [7:0] b;
    case (idx)
      3'd0:    b = SYNC_BYTE;
      3'd1:    b = {7'd0, m};
      3'd2:    b = m ? pos[15:8] : 8'h00;
      3'd3:    b = m ? pos[7:0]  : 8'h00;
      3'd4:    b = m ? ch        : 8'h00;
      default: b = 8'h00;
    endcase
    return b;
  endfunction

  logic [1:0]  state_q,      state_d;
  logic [2:0]  idx_q,        idx_d;
  logic        cur_match_q,  cur_match_d;
  logic [15:0] cur_pos_q,    cur_pos_d;
  logic [7:0]  cur_char_q,   cur_char_d;
  logic        pend_valid_q, pend_valid_d;
  logic        pend_match_q, pend_match_d;
  logic [15:0] pend_pos_q,   pend_pos_d;
  logic [7:0]  pend_char_q,  pend_char_d;
  logic        start_q,      start_d;
  logic [7:0]  data_q,       data_d;
  logic        overrun_q,    overrun_d;

  logic        launch;       // want to issue the byte at idx_d this edge
  logic        took_direct;  // proc_done became the active packet

  always_comb begin
    // NOTE: every signal assigned here gets a default first, so no path
    // leaves one unassigned and no latch is inferred.
    state_d      = state_q;
    idx_d        = idx_q;
    cur_match_d  = cur_match_q;
    cur_pos_d    = cur_pos_q;
    cur_char_d   = cur_char_q;
    pend_valid_d = pend_valid_q;
    pend_match_d = pend_match_q;
    pend_pos_d   = pend_pos_q;
    pend_char_d  = pend_char_q;
    overrun_d    = overrun_q;
    start_d      = 1'b0;
    data_d       = data_q;
    launch       = 1'b0;
    took_direct  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (proc_done) begin
          cur_match_d = proc_match;
          cur_pos_d   = proc_byte_pos;
          cur_char_d  = proc_match_char;
          idx_d       = 3'd0;
          state_d     = ST_START;
          launch      = 1'b1;
          took_direct = 1'b1;
        end
      end

      ST_START: begin
        // start_q high means this is the cycle the pulse is on the wire.
        if (start_q) state_d = ST_GUARD;
        else         launch  = 1'b1;
      end

      ST_GUARD: state_d = ST_WAIT;

      ST_WAIT: begin
        if (!txd_busy) begin
          if (idx_q != LAST_IDX) begin
            idx_d   = idx_q + 3'd1;
            state_d = ST_START;
            launch  = 1'b1;
          end else begin
            idx_d = 3'd0;
            if (pend_valid_q) begin
              // The slot frees on the same edge its byte 0 start is issued.
              cur_match_d  = pend_match_q;
              cur_pos_d    = pend_pos_q;
              cur_char_d   = pend_char_q;
              pend_valid_d = 1'b0;
              state_d      = ST_START;
              launch       = 1'b1;
            end else if (proc_done) begin
              // Result arriving exactly at packet completion goes straight out.
              cur_match_d = proc_match;
              cur_pos_d   = proc_byte_pos;
              cur_char_d  = proc_match_char;
              state_d     = ST_START;
              launch      = 1'b1;
              took_direct = 1'b1;
            end else begin
              state_d = ST_IDLE;
            end
          end
        end
      end

      default: state_d = ST_IDLE;
    endcase

    // Any result not taken as the active packet goes to the pending slot.
    // Checking pend_valid_d lets a result land in a slot freed this edge.
    if (proc_done && !took_direct) begin
      if (!pend_valid_d) begin
        pend_valid_d = 1'b1;
        pend_match_d = proc_match;
        pend_pos_d   = proc_byte_pos;
        pend_char_d  = proc_match_char;
      end else begin
        overrun_d = 1'b1;
      end
    end

    if (launch && !txd_busy) begin
      start_d = 1'b1;
      data_d  = byte_sel(idx_d, cur_match_d, cur_pos_d, cur_char_d);
    end
  end

  // NOTE: the captured-result and pending-slot datapath registers are reset
  // along with the control state, so nothing from an aborted packet survives.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      idx_q        <= 3'd0;
      cur_match_q  <= 1'b0;
      cur_pos_q    <= 16'h0000;
      cur_char_q   <= 8'h00;
      pend_valid_q <= 1'b0;
      pend_match_q <= 1'b0;
      pend_pos_q   <= 16'h0000;
      pend_char_q  <= 8'h00;
      start_q      <= 1'b0;
      data_q       <= 8'h00;
      overrun_q    <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the
      // pre-edge values regardless of statement order.
      state_q      <= state_d;
      idx_q        <= idx_d;
      cur_match_q  <= cur_match_d;
      cur_pos_q    <= cur_pos_d;
      cur_char_q   <= cur_char_d;
      pend_valid_q <= pend_valid_d;
      pend_match_q <= pend_match_d;
      pend_pos_q   <= pend_pos_d;
      pend_char_q  <= pend_char_d;
      start_q      <= start_d;
      data_q       <= data_d;
      overrun_q    <= overrun_d;
    end
  end

  assign txd_start   = start_q;
  assign txd_data    = data_q;
  assign rpt_busy    = (state_q != ST_IDLE) || pend_valid_q;
  assign rpt_overrun = overrun_q;

endmodule
